// File: rtl/servisia_pkg.sv
// Shared definitions for the servisia Wishbone arbiter: FSM encoding and
// timeout counter width.
package servisia_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/servisia_wb_timeout.sv
// Cycle counter for a BUSY transaction; flags when the slave has been silent
// for the configured number of cycles.
module servisia_wb_timeout
   import servisia_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == limit);

endmodule

// File: rtl/servisia_wb_arb2.sv
// Two-master round-robin Wishbone arbiter in front of a single slave, with a
// bounded wait that terminates a stalled transaction with an error ack.
module servisia_wb_arb2
   import servisia_pkg::*;
#(
   parameter int DW      = 2,
   parameter int AW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic          m0_we_i,
   input  logic          m0_stb_i,
   output logic [DW-1:0] m0_rdt_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic          m1_we_i,
   input  logic          m1_stb_i,
   output logic [DW-1:0] m1_rdt_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic          s_we_o,
   output logic          s_stb_o,
   input  logic [DW-1:0] s_rdt_i,
   input  logic          s_ack_i
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   arb_state_t state;
   logic       gnt;
   logic       prio;
   logic       busy;
   logic       expired;
   logic       done;
   logic       err;
   logic       rd_ok;

   assign busy = (state == ARB_BUSY);

   // Counter sits at zero whenever idle, so it is clear on BUSY entry.
   servisia_wb_timeout u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clr     (!busy),
      .en      (busy && !s_ack_i),
      .limit   (LIMIT),
      .expired (expired)
   );

   // A real ack wins over a coincident timeout.
   assign done  = busy && (s_ack_i || expired);
   assign err   = busy && expired && !s_ack_i;
   assign rd_ok = busy && s_ack_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= ARB_IDLE;
         gnt   <= 1'b0;
         prio  <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE:
               if (m0_stb_i || m1_stb_i) begin
                  gnt   <= (m0_stb_i && m1_stb_i) ? prio : m1_stb_i;
                  state <= ARB_BUSY;
               end
            ARB_BUSY:
               if (done) begin
                  prio  <= ~gnt;
                  state <= ARB_IDLE;
               end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign s_stb_o  = busy;
   assign s_adr_o  = gnt ? m1_adr_i : m0_adr_i;
   assign s_dat_o  = gnt ? m1_dat_i : m0_dat_i;
   assign s_we_o   = gnt ? m1_we_i  : m0_we_i;

   assign m0_ack_o = done && !gnt;
   assign m1_ack_o = done &&  gnt;
   assign m0_err_o = err  && !gnt;
   assign m1_err_o = err  &&  gnt;
   assign m0_rdt_o = (rd_ok && !gnt) ? s_rdt_i : '0;
   assign m1_rdt_o = (rd_ok &&  gnt) ? s_rdt_i : '0;

endmodule

// File: tb/tb_servisia_wb_arb2.sv
// Bench for servisia_wb_arb2 with a single-cycle registered-ack GPIO slave.
module tb_servisia_wb_arb2;

   localparam int DW = 2;
   localparam int AW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] m0_adr, m1_adr, s_adr;
   logic [DW-1:0] m0_dat, m1_dat, s_dat, m0_rdt, m1_rdt, s_rdt;
   logic          m0_we, m1_we, s_we, m0_stb, m1_stb, s_stb;
   logic          m0_ack, m1_ack, m0_err, m1_err, s_ack;
   logic          ack_en, gpio_i, gpio_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   servisia_wb_arb2 #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
      .wb_clk_i (clk),    .wb_rst_ni (rst_n),
      .m0_adr_i (m0_adr), .m0_dat_i (m0_dat), .m0_we_i (m0_we), .m0_stb_i (m0_stb),
      .m0_rdt_o (m0_rdt), .m0_ack_o (m0_ack), .m0_err_o (m0_err),
      .m1_adr_i (m1_adr), .m1_dat_i (m1_dat), .m1_we_i (m1_we), .m1_stb_i (m1_stb),
      .m1_rdt_o (m1_rdt), .m1_ack_o (m1_ack), .m1_err_o (m1_err),
      .s_adr_o  (s_adr),  .s_dat_o  (s_dat),  .s_we_o  (s_we),  .s_stb_o  (s_stb),
      .s_rdt_i  (s_rdt),  .s_ack_i  (s_ack)
   );

   // GPIO slave: one output bit, one input bit, registered ack
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack  <= 1'b0;
         gpio_o <= 1'b0;
      end else begin
         s_ack <= s_stb && !s_ack && ack_en;
         if (s_stb && !s_ack && ack_en && s_we) gpio_o <= s_dat[0];
      end
   end
   assign s_rdt = {gpio_i, gpio_o};

   // {s_stb, m0_ack, m0_err, m1_ack, m1_err, m0_rdt, m1_rdt}
   logic [8:0] outs;
   assign outs = {s_stb, m0_ack, m0_err, m1_ack, m1_err, m0_rdt, m1_rdt};
   logic [8:0] want;

   task reset_dut;
      rst_n  = 1'b0;
      m0_stb = 1'b0; m1_stb = 1'b0;
      m0_we  = 1'b0; m1_we  = 1'b0;
      m0_dat = '0;   m1_dat = '0;
      m0_adr = '0;   m1_adr = '0;
      ack_en = 1'b1; gpio_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task test_reset;
      rst_n = 1'b0;
      m0_adr = 4'hA; m0_dat = 2'b10; m0_we = 1'b1; m0_stb = 1'b1;
      m1_adr = 4'h5; m1_dat = 2'b01; m1_we = 1'b0; m1_stb = 1'b1;
      ack_en = 1'b1; gpio_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== 9'd0) begin
            failures++;
            $display("FAIL reset_outs i=%0d got=%b exp=%b", i, outs, 9'd0);
         end
         checks++;
         if ({s_adr, s_dat, s_we} !== {4'hA, 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL reset_mirror got=%h exp=%h", {s_adr, s_dat, s_we}, {4'hA, 2'b10, 1'b1});
         end
      end
      reset_dut();
   endtask

   task test_write;
      reset_dut();
      m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 2'b01; m0_adr = 4'h3;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) m0_stb = 1'b0;
         @(negedge clk);
         want = '0;
         want[8] = (c == 1 || c == 2);
         want[7] = (c == 2);
         if (c == 2) want[3:2] = 2'b01;
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL write c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (gpio_o !== 1'b1) begin
         failures++;
         $display("FAIL write_gpio got=%b exp=1", gpio_o);
      end
      // prio now points at m1: a simultaneous request must go to m1
      m0_stb = 1'b1; m0_we = 1'b0; m1_stb = 1'b1; m1_we = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         want = '0;
         want[8] = (c != 0);
         want[5] = (c == 2);
         if (c == 2) want[1:0] = 2'b01;
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL write_prio c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
      m0_stb = 1'b0; m1_stb = 1'b0;
   endtask

   task test_both;
      reset_dut();
      m0_stb = 1'b1; m1_stb = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) m0_stb = 1'b0;
         if (c == 6) m1_stb = 1'b0;
         @(negedge clk);
         want = '0;
         want[8] = (c == 1 || c == 2 || c == 4 || c == 5);
         want[7] = (c == 2);
         want[5] = (c == 5);
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL both c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task test_read;
      reset_dut();
      gpio_i = 1'b1;
      m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 4'h7;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) m1_stb = 1'b0;
         @(negedge clk);
         want = '0;
         want[8] = (c == 1 || c == 2);
         want[5] = (c == 2);
         if (c == 2) want[1:0] = 2'b10;
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL read c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task test_timeout;
      reset_dut();
      ack_en = 1'b0;
      m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 2'b01;
      for (int c = 0; c < 7; c++) begin
         if (c == 5) m0_stb = 1'b0;
         @(negedge clk);
         want = '0;
         want[8] = (c >= 1 && c <= TO);
         want[7] = (c == TO);
         want[6] = (c == TO);
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL timeout c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
      ack_en = 1'b1;
   endtask

   task test_reset_mid;
      reset_dut();
      // m0 transaction leaves prio pointing at m1
      m0_stb = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) m0_stb = 1'b0;
         @(posedge clk); #1;
      end
      m1_stb = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_stb !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_busy got=%b exp=1", s_stb);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== 9'd0) begin
         failures++;
         $display("FAIL rstmid_async got=%b exp=%b", outs, 9'd0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== 9'd0) begin
         failures++;
         $display("FAIL rstmid_hold got=%b exp=%b", outs, 9'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m0_stb = 1'b1; m1_stb = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         want = '0;
         want[8] = (c != 0);
         want[7] = (c == 2);
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL rstmid_prio c=%0d got=%b exp=%b", c, outs, want);
         end
         @(posedge clk); #1;
      end
      m0_stb = 1'b0; m1_stb = 1'b0;
   endtask

   task test_alternate;
      int ack_c[$];
      bit ack_m[$];
      int  errs;
      reset_dut();
      errs = 0;
      m0_stb = 1'b1; m1_stb = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (m0_ack) begin ack_c.push_back(c); ack_m.push_back(1'b0); end
         if (m1_ack) begin ack_c.push_back(c); ack_m.push_back(1'b1); end
         if (m0_err || m1_err) errs++;
         @(posedge clk); #1;
      end
      m0_stb = 1'b0; m1_stb = 1'b0;
      checks++;
      if (ack_c.size() < 8 || errs != 0) begin
         failures++;
         $display("FAIL alt_count got=%0d errs=%0d exp>=8 errs=0", ack_c.size(), errs);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (ack_m[i] !== 1'(i % 2) || ack_c[i] != 2 + 3 * i) begin
               failures++;
               $display("FAIL alt_txn i=%0d got=m%0d@%0d exp=m%0d@%0d",
                        i, ack_m[i], ack_c[i], i % 2, 2 + 3 * i);
            end
         end
      end
   endtask

   // Transaction-level reference: an idle arbiter picks a requester (prio on
   // ties), the ack lands two cycles later, one idle cycle follows.
   task test_random;
      int   g, free_at;
      logic w, prio_m, gm, drop0, drop1;
      reset_dut();
      g = -10; free_at = 0; prio_m = 1'b0; gm = 1'b0; w = 1'b0;
      drop0 = 1'b0; drop1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (drop0) begin m0_stb = 1'b0; drop0 = 1'b0; end
         if (drop1) begin m1_stb = 1'b0; drop1 = 1'b0; end
         if (!m0_stb && $urandom_range(0, 2) == 0) begin
            m0_stb = 1'b1; m0_we = 1'($urandom_range(0, 1));
            m0_dat = DW'($urandom); m0_adr = AW'($urandom);
         end
         if (!m1_stb && $urandom_range(0, 2) == 0) begin
            m1_stb = 1'b1; m1_we = 1'($urandom_range(0, 1));
            m1_dat = DW'($urandom); m1_adr = AW'($urandom);
         end
         gpio_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         want = '0;
         want[8] = (c == g + 1 || c == g + 2);
         if (c == g + 2) begin
            if (!w) begin want[7] = 1'b1; want[3:2] = {gpio_i, gm}; end
            else    begin want[5] = 1'b1; want[1:0] = {gpio_i, gm}; end
         end
         checks++;
         if (outs !== want) begin
            failures++;
            $display("FAIL random c=%0d got=%b exp=%b", c, outs, want);
         end
         if (c == g + 2) begin
            if (w) drop1 = 1'b1; else drop0 = 1'b1;
         end
         if (c >= free_at && (m0_stb || m1_stb)) begin
            w       = (m0_stb && m1_stb) ? prio_m : m1_stb;
            prio_m  = ~w;
            g       = c;
            free_at = c + 3;
            if (w ? m1_we : m0_we) gm = w ? m1_dat[0] : m0_dat[0];
         end
         @(posedge clk); #1;
      end
      m0_stb = 1'b0; m1_stb = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_both();
      test_read();
      test_timeout();
      test_reset_mid();
      test_alternate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/servisia_wb_arb2.md
SERVISIA_WB_ARB2 -- requirements
Module: servisia_wb_arb2

Interface
REQ-001 SHALL have parameter DW, default 2, meaning the data width (INP_WIDTH+OUT_WIDTH of the attached GPIO slave).
REQ-002 SHALL have parameter AW, default 4, meaning the address width passed through to the slave.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the number of BUSY cycles without s_ack before an error termination (range 1..255).
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port wb_rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports m0_adr_i input AW, m0_dat_i input DW, m0_we_i input 1, m0_stb_i input 1: master 0 request.
REQ-007 SHALL have ports m0_rdt_o output DW, m0_ack_o output 1, m0_err_o output 1: master 0 response.
REQ-008 SHALL have ports m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_rdt_o, m1_ack_o, m1_err_o: the identical set for master 1.
REQ-009 SHALL have ports s_adr_o output AW, s_dat_o output DW, s_we_o output 1, s_stb_o output 1: the shared slave request.
REQ-010 SHALL have ports s_rdt_i input DW and s_ack_i input 1: the shared slave response.

Function
REQ-011 SHALL implement the two-state FSM IDLE and BUSY, plus a 1-bit grant register gnt and a 1-bit priority pointer prio.
REQ-012 In IDLE with exactly one mN_stb_i high, SHALL load gnt=N and enter BUSY at the next edge.
REQ-013 In IDLE with both stb high, SHALL grant gnt=prio.
REQ-014 In IDLE with no stb high, SHALL remain in IDLE with gnt unchanged.
REQ-015 In BUSY, s_stb_o SHALL be 1 and s_adr_o, s_dat_o and s_we_o SHALL combinationally mirror master gnt.
REQ-016 In IDLE, s_stb_o SHALL be 0 and s_adr_o, s_dat_o and s_we_o SHALL mirror master gnt.
REQ-017 In BUSY with s_ack_i=1, SHALL drive mgnt_ack_o=1 and mgnt_rdt_o=s_rdt_i combinationally in that cycle; at the next edge it SHALL enter IDLE and set prio=~gnt.
REQ-018 The non-granted master SHALL see ack=0, err=0 and rdt=0 at all times.
REQ-019 A grant SHALL NOT change while in BUSY, even if the granted stb drops early or the other master raises stb.
REQ-020 A 8-bit counter SHALL clear on entry to BUSY and increment on each BUSY cycle without s_ack_i.
REQ-021 When the counter equals TIMEOUT-1 and s_ack_i=0, SHALL drive mgnt_ack_o=1, mgnt_err_o=1 and mgnt_rdt_o=0 for that cycle, then enter IDLE and rotate prio as in REQ-017.
REQ-022 When s_ack_i and the timeout condition coincide, SHALL treat the cycle as a normal ack with err=0.
REQ-023 s_ack_i arriving in IDLE SHALL be ignored, with no master ack.
REQ-024 The minimum transaction SHALL take 2 cycles (IDLE grant cycle, BUSY ack cycle), with a mandatory IDLE cycle between consecutive grants.
REQ-025 With the attached single-cycle GPIO slave, a request seen in cycle 0 SHALL produce a master ack in cycle 2, because the slave registers its ack.

Reset
REQ-026 Asserting wb_rst_ni=0 SHALL immediately force state=IDLE, gnt=0, prio=0 and counter=0, so that s_stb_o and all ack/err outputs go to 0 without a clock.
REQ-027 Reset asserted mid-BUSY SHALL abort the transaction with no ack to either master.
REQ-028 All outputs SHALL be 0 during reset, except s_adr_o, s_dat_o and s_we_o, which mirror master 0.

Structure
REQ-029 Shared package servisia_pkg SHALL hold the FSM state encoding constants (ARB_IDLE=1'b0, ARB_BUSY=1'b1) and the timeout counter width constant (8).
REQ-030 The timeout counter and compare logic SHALL be the single sub-module servisia_wb_timeout (ports: clk, rst_n, clr, en, limit, expired).
REQ-031 All other logic SHALL reside in servisia_wb_arb2, with no further hierarchy.

Verification
REQ-032 Bench SHALL cover: m0 write dat=2'b01 with the GPIO slave attached -> s_stb_o high in cycles 1-2, m0_ack_o=1 in cycle 2, gpio_o=1 afterwards, prio=1.
REQ-033 Bench SHALL cover: m0 and m1 raising stb in the same cycle from reset -> m0 served first (ack in cycle 2), m1 granted in cycle 3 and acked in cycle 5.
REQ-034 Bench SHALL cover: m1 read with gpio_i=1, gpio_o=0 -> m1_rdt_o=2'b10 on the ack cycle, m0_rdt_o=0 throughout.
REQ-035 Bench SHALL cover: slave ack tied low, TIMEOUT=4 -> m0_ack_o=1 and m0_err_o=1 exactly 4 cycles after entering BUSY, then IDLE.
REQ-036 Bench SHALL cover: wb_rst_ni pulled low mid-BUSY, between clock edges -> s_stb_o=0 immediately, no ack, and the next request after release is arbitrated with prio=0.
REQ-037 Bench SHALL cover: both masters continuously requesting for 8 transactions -> grants alternate m0, m1, m0, ... with no grant gap longer than one IDLE cycle.
